// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and bit-timing helpers.
package uart_rx_deserializer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Integer clocks per bit; the fractional part is dropped.
  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_deserializer_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= INIT;
      sync_p1 <= INIT;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes RXD, centres on each bit, and emits one strobe per framed byte.
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic              clk,
  input  logic              dev_rst,
  input  logic              uart_rxd,
  output logic              uart_rx_valid,
  output logic [BYTE_W-1:0] uart_rx_data,
  output logic              uart_rx_busy,
  output logic              uart_rx_frame_err
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (CLKS_PER_BIT < 4) begin : g_rate_check
    $error("uart_rx_deserializer: CLKS_PER_BIT must be at least 4");
  end

  logic                rxd_s;
  rx_state_t           state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [BYTE_W-1:0]   shreg;
  logic                shift_en;
  logic                load;
  logic                ferr_nxt;

  sync_2ff #(.INIT(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (dev_rst),
    .d     (uart_rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk) begin
    if (!dev_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Leaving IDLE early in START rejects glitches shorter than half a bit.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_ONE;
    bit_idx_nxt = bit_idx;
    shift_en    = 1'b0;
    load        = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxd_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rxd_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!dev_rst) begin
      cnt               <= '0;
      bit_idx           <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_data      <= '0;
    end else begin
      cnt               <= cnt_nxt;
      bit_idx           <= bit_idx_nxt;
      uart_rx_valid     <= load;
      uart_rx_frame_err <= ferr_nxt;
      if (load) uart_rx_data <= shreg;
    end
  end

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rxd_s, shreg[BYTE_W-1:1]};
  end

  assign uart_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at 10 clocks per bit.
module tb_uart_rx_deserializer;

  localparam int CPB     = 10;
  localparam int LATENCY = 2 + 5 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       dev_rst = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_busy;
  logic       uart_rx_frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         err_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_deserializer #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk              (clk),
    .dev_rst          (dev_rst),
    .uart_rxd         (uart_rxd),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .uart_rx_busy     (uart_rx_busy),
    .uart_rx_frame_err(uart_rx_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives one frame starting at the current negedge. A low stop bit is left low for the caller to release.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic track);
    exp_t e;
    uart_rxd = 1'b0;
    if (track) begin
      if (stop) begin
        e.data = b;
        e.cyc  = cyc + LATENCY;
        exp_q.push_back(e);
      end else begin
        err_q.push_back(cyc + LATENCY);
      end
    end
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (uart_rx_valid && uart_rx_frame_err)
      check("strobes_exclusive", 1, 0);
    if (uart_rx_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", uart_rx_data, e.data);
        check("valid_cycle", cyc, e.cyc);
        last_good = e.data;
      end
    end
    if (uart_rx_frame_err) begin
      if (err_q.size() == 0) begin
        check("unexpected_frame_err", 1, 0);
      end else begin
        int c;
        c = err_q.pop_front();
        check("frame_err_cycle", cyc, c);
        check("data_held_on_err", uart_rx_data, last_good);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", uart_rx_valid, 0);
    check("rst_data", uart_rx_data, 0);
    check("rst_busy", uart_rx_busy, 0);
    check("rst_ferr", uart_rx_frame_err, 0);
    dev_rst = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte
    send_frame(8'h04, 1'b1, 1'b1);
    check("t1_busy_after", uart_rx_busy, 0);
    check("t1_received", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    // Back-to-back, zero gap
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    check("t2_received", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    // Short glitch rejected
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_busy_glitch", uart_rx_busy, 1);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_busy_cleared", uart_rx_busy, 0);
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (5) @(negedge clk);

    // Framing error with held-low line
    send_frame(8'h00, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    check("t4_busy_break", uart_rx_busy, 1);
    check("t4_err_seen", err_q.size(), 0);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busy_released", uart_rx_busy, 0);
    check("t4_data_kept", uart_rx_data, 8'h55);
    repeat (3) @(negedge clk);

    // Reset mid-frame
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (40) @(negedge clk);
        dev_rst = 1'b0;
        last_good = 8'h00;
        @(negedge clk);
        check("t5_rst_valid", uart_rx_valid, 0);
        check("t5_rst_data", uart_rx_data, 0);
        check("t5_rst_busy", uart_rx_busy, 0);
        check("t5_rst_ferr", uart_rx_frame_err, 0);
        dev_rst = 1'b1;
        @(negedge clk);
        check("t5_post_busy", uart_rx_busy, 0);
        check("t5_post_data", uart_rx_data, 0);
      end
    join
    send_frame(8'h81, 1'b1, 1'b1);
    check("t5_received", exp_q.size(), 0);
    repeat (5) @(negedge clk);

    // Randomized traffic, occasional framing errors
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      int         gap;
      logic       bad;
      b   = 8'($urandom);
      gap = $urandom_range(0, 12);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, 1'b1);
      if (bad) begin
        repeat ($urandom_range(5, 25)) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (3 + gap) @(negedge clk);
      end else begin
        repeat (gap) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    check("final_valid_queue", exp_q.size(), 0);
    check("final_err_queue", err_q.size(), 0);
    check("final_busy", uart_rx_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
